// File: rtl/word_deserializer32.sv
// word_deserializer32 -- scatters a stream of W-bit words into an N*W-bit frame.
//
// Word k of a frame lands in a[k*W +: W]. A full frame, or a flushed partial
// frame, is then held and offered downstream with out_valid/out_ready. Releasing
// it clears the frame and costs one idle input cycle.
//
// Ports:
//   clk, rst_n            clock and asynchronous active-low reset
//   in_data/in_valid/in_ready   word input handshake
//   flush                 close the current partial frame early (ignored when empty)
//   a [N*W]               packed frame, slot k = a[k*W +: W]
//   count [SW+1]          number of valid words in the frame (0..N)
//   out_valid/out_ready   frame output handshake
//   rd_sel/rd_data        single-slot readback, only with WORD_READBACK_EN defined
//
// Optional feature macro: WORD_READBACK_EN

module word_deserializer32_slot #(
  parameter int W = 32
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         we,
  input  logic         clr,
  input  logic [W-1:0] d,
  output logic [W-1:0] q
);
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)   q <= '0;
    else if (clr) q <= '0;
    else if (we)  q <= d;
  end
endmodule

module word_deserializer32 #(
  parameter  int N  = 32,
  parameter  int W  = 32,
  localparam int SW = $clog2(N)
) (
  input  logic           clk,
  input  logic           rst_n,
  input  logic [W-1:0]   in_data,
  input  logic           in_valid,
  output logic           in_ready,
  input  logic           flush,
  output logic [N*W-1:0] a,
  output logic [SW:0]    count,
  output logic           out_valid,
`ifdef WORD_READBACK_EN
  input  logic [4:0]     rd_sel,
  output logic [W-1:0]   rd_data,
`endif
  input  logic           out_ready
);

  typedef enum logic {FILL = 1'b0, HOLD = 1'b1} state_t;

  state_t              state, state_nx;
  logic [SW:0]         idx;
  logic                wr, last, clr;
  logic [N-1:0][W-1:0] slots;

  // in_ready is gated by rst_n so it drops immediately when reset asserts.
  assign in_ready  = (state == FILL) && rst_n;
  assign out_valid = (state == HOLD);
  assign wr        = in_valid && in_ready;
  assign last      = (idx == (SW+1)'(N-1));
  assign clr       = out_valid && out_ready;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= FILL;
    else        state <= state_nx;
  end

  // A flush only closes a frame that holds, or is receiving, at least one word.
  always_comb begin
    state_nx = state;
    case (state)
      FILL: if ((wr && last) || (flush && ((idx != '0) || wr))) state_nx = HOLD;
      HOLD: if (out_ready) state_nx = FILL;
      default: state_nx = FILL;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      idx   <= '0;
      count <= '0;
    end else if (clr) begin
      idx   <= '0;
      count <= '0;
    end else if (wr) begin
      idx   <= idx + 1'b1;
      count <= idx + 1'b1;
    end
  end

  for (genvar k = 0; k < N; k++) begin : g_slot
    word_deserializer32_slot #(.W(W)) u_slot (
      .clk   (clk),
      .rst_n (rst_n),
      .we    (wr && (idx == (SW+1)'(k))),
      .clr   (clr),
      .d     (in_data),
      .q     (slots[k])
    );
  end

  assign a = slots;

`ifdef WORD_READBACK_EN
  // Out-of-range selects read as zero, like the multiplexer.
  always_comb begin
    rd_data = '0;
    for (int k = 0; k < N; k++)
      if (int'(rd_sel) == k) rd_data = slots[k];
  end
`endif

endmodule

// File: tb/tb_word_deserializer32.sv
module tb_word_deserializer32;
  localparam int N  = 32;
  localparam int W  = 32;
  localparam int SW = $clog2(N);

  logic           clk = 0;
  logic           rst_n;
  logic [W-1:0]   in_data;
  logic           in_valid;
  logic           in_ready;
  logic           flush;
  logic [N*W-1:0] a;
  logic [SW:0]    count;
  logic           out_valid;
  logic           out_ready;
`ifdef WORD_READBACK_EN
  logic [4:0]     rd_sel;
  logic [W-1:0]   rd_data;
`endif

  int tests = 0;
  int fails = 0;

  word_deserializer32 #(.N(N), .W(W)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_data   (in_data),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .flush     (flush),
    .a         (a),
    .count     (count),
    .out_valid (out_valid),
`ifdef WORD_READBACK_EN
    .rd_sel    (rd_sel),
    .rd_data   (rd_data),
`endif
    .out_ready (out_ready)
  );

  always #5 clk = ~clk;

  // Frame model: the frame is just the list of words received so far; it is
  // closed when it reaches N words or a flush arrives while non-empty.
  logic [W-1:0] mq[$];
  bit           m_hold;

  always @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      mq.delete();
      m_hold = 0;
    end else if (!m_hold) begin
      if (in_valid) mq.push_back(in_data);
      if (mq.size() == N || (flush && mq.size() > 0)) m_hold = 1;
    end else if (out_ready) begin
      mq.delete();
      m_hold = 0;
    end
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  function automatic logic [W-1:0] slot(input int k);
    return a[k*W +: W];
  endfunction

  task automatic model_check();
    int bad = -1;
    logic [W-1:0] e;
    check("model count", 64'(count), 64'(mq.size()));
    check("model out_valid", 64'(out_valid), 64'(m_hold));
    check("model in_ready", 64'(in_ready), 64'(!m_hold && rst_n));
    for (int k = 0; k < N; k++) begin
      e = (k < mq.size()) ? mq[k] : '0;
      if (bad < 0 && slot(k) !== e) bad = k;
    end
    tests++;
    if (bad >= 0) begin
      fails++;
      e = (bad < mq.size()) ? mq[bad] : '0;
      $display("FAIL model frame slot %0d: got 0x%0h, expected 0x%0h", bad, slot(bad), e);
    end
  endtask

  // Advance one clock; inputs change 1 ns after the edge, outputs checked then.
  task automatic step();
    @(posedge clk);
    #1;
    model_check();
  endtask

  task automatic idle();
    in_valid = 0; flush = 0; out_ready = 0; in_data = '0;
  endtask

  task automatic release_frame();
    idle();
    out_ready = 1;
    step();
    out_ready = 0;
  endtask

  initial begin
    rst_n = 0;
    idle();
`ifdef WORD_READBACK_EN
    rd_sel = 0;
`endif
    #1;
    step(); step();
    check("reset count", 64'(count), 64'd0);
    check("reset out_valid", 64'(out_valid), 64'd0);
    check("reset in_ready", 64'(in_ready), 64'd0);
    check("reset a zero", 64'(a == '0), 64'd1);
    rst_n = 1;
    step();
    check("idle in_ready", 64'(in_ready), 64'd1);

    // Full frame.
    for (int k = 0; k < N; k++) begin
      in_valid = 1;
      in_data  = 32'h1000_0000 + W'(k);
      step();
      if (k == N-2) begin
        check("full: out_valid before last", 64'(out_valid), 64'd0);
        check("full: count 31", 64'(count), 64'd31);
      end
    end
    check("full: out_valid", 64'(out_valid), 64'd1);
    check("full: count 32", 64'(count), 64'd32);
    check("full: in_ready in HOLD", 64'(in_ready), 64'd0);
    check("full: slot 0", 64'(slot(0)), 64'h1000_0000);
    check("full: slot 31", 64'(slot(31)), 64'h1000_001F);
`ifdef WORD_READBACK_EN
    rd_sel = 5'd7;
    #1;
    check("readback slot 7", 64'(rd_data), 64'h1000_0007);
`endif

    // Backpressure: in_valid and flush held high in HOLD must not disturb the frame.
    in_valid = 1; in_data = 32'hBAD0_BAD0; flush = 1;
    repeat (5) step();
    check("hold: slot 5 stable", 64'(slot(5)), 64'h1000_0005);
    check("hold: count stable", 64'(count), 64'd32);
    release_frame();
    check("release: count", 64'(count), 64'd0);
    check("release: a zero", 64'(a == '0), 64'd1);
    check("release: out_valid", 64'(out_valid), 64'd0);
    check("release: in_ready", 64'(in_ready), 64'd1);

    // Partial flush.
    for (int k = 1; k <= 3; k++) begin
      in_valid = 1; in_data = 32'hAAAA_0000 + W'(k);
      step();
    end
    idle(); flush = 1;
    step();
    flush = 0;
    check("partial: count", 64'(count), 64'd3);
    check("partial: out_valid", 64'(out_valid), 64'd1);
    check("partial: slot 2", 64'(slot(2)), 64'hAAAA_0003);
    check("partial: slot 3 zero", 64'(slot(3)), 64'd0);
    release_frame();

    // Flush on empty frame is ignored; flush with the 5th write includes it.
    flush = 1;
    step();
    flush = 0;
    check("empty flush: out_valid", 64'(out_valid), 64'd0);
    check("empty flush: in_ready", 64'(in_ready), 64'd1);
    for (int k = 0; k < 4; k++) begin
      in_valid = 1; in_data = 32'h5555_0000 + W'(k);
      step();
    end
    in_data = 32'hDEAD_BEEF; flush = 1;
    step();
    idle();
    check("flush+write: count", 64'(count), 64'd5);
    check("flush+write: slot 4", 64'(slot(4)), 64'hDEAD_BEEF);
    check("flush+write: out_valid", 64'(out_valid), 64'd1);
    release_frame();

    // Reset mid-frame after 10 writes.
    for (int k = 0; k < 10; k++) begin
      in_valid = 1; in_data = 32'h7000_0000 + W'(k);
      step();
    end
    check("pre-reset count", 64'(count), 64'd10);
    rst_n = 0;
    #1;
    model_check();
    check("mid reset: count", 64'(count), 64'd0);
    check("mid reset: a zero", 64'(a == '0), 64'd1);
    check("mid reset: out_valid", 64'(out_valid), 64'd0);
    check("mid reset: in_ready", 64'(in_ready), 64'd0);
    step();
    rst_n = 1;
    in_valid = 1; in_data = 32'h0BAD_F00D;
    step();
    in_data = 32'h0000_1234;
    step();
    idle();
    check("after reset: slot 0", 64'(slot(0)), 64'h0BAD_F00D);
    check("after reset: slot 1", 64'(slot(1)), 64'h0000_1234);
    check("after reset: count", 64'(count), 64'd2);
    step();

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
